// File: rtl/mudi_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, HI/LO read
// select, default latencies and the pure arithmetic helpers used by mudi_unit.
package mudi_pkg;

    typedef enum logic [2:0] {
        MUDI_OTH   = 3'd0,
        MUDI_MULT  = 3'd1,
        MUDI_MULTU = 3'd2,
        MUDI_DIV   = 3'd3,
        MUDI_DIVU  = 3'd4,
        MUDI_MTHI  = 3'd5,
        MUDI_MTLO  = 3'd6
    } mudi_op_e;

    localparam logic HL_LO = 1'b0;
    localparam logic HL_HI = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Sign-extending to 64 bits first makes one unsigned multiply cover both mult and multu.
    function automatic hilo_t mudi_mul(input logic [31:0] a, input logic [31:0] b,
                                       input logic is_signed);
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        logic [63:0] prod;
        a_ext = {{32{is_signed & a[31]}}, a};
        b_ext = {{32{is_signed & b[31]}}, b};
        prod  = a_ext * b_ext;
        return '{hi: prod[63:32], lo: prod[31:0]};
    endfunction

    // Magnitude divide then re-sign: quotient truncates toward zero, remainder takes the
    // dividend's sign, and 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
    function automatic hilo_t mudi_div(input logic [31:0] a, input logic [31:0] b,
                                       input logic is_signed);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? 32'(32'd0 - a) : a;
        b_mag = b_neg ? 32'(32'd0 - b) : b;
        if (b_mag == 32'd0) begin
            b_mag = 32'd1;
        end
        q = a_mag / b_mag;
        r = a_mag % b_mag;
        if (a_neg ^ b_neg) begin
            q = 32'(32'd0 - q);
        end
        if (a_neg) begin
            r = 32'(32'd0 - r);
        end
        return '{hi: r, lo: q};
    endfunction

endpackage

// File: rtl/mudi_timer.sv
// Loadable down-counter for the multiply/divide unit: holds Busy while an
// operation is in flight and pulses done on the last busy cycle.
module mudi_timer
    import mudi_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             done_o
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                if (load_i) begin
                    state_d = T_RUN;
                    cnt_d   = load_val_i;
                end
            end
            T_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    done_o  = 1'b1;
                    state_d = T_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = T_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == T_RUN);

endmodule

// File: rtl/mudi_unit.sv
// E-stage multiply/divide unit holding HI/LO. Define MDU_DIVZERO_FAST_EN to make
// a divide by zero complete immediately instead of occupying the full divide latency.
module mudi_unit
    import mudi_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic        MDStart,
    input  logic        HLOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        Busy,
    output logic [31:0] HLOut
);

    mudi_op_e         op;
    logic             is_mul;
    logic             is_div;
    logic             div_zero;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             done;
    hilo_t            res;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] ph_q, ph_d;
    logic [31:0] pl_q, pl_d;
    logic        pv_q, pv_d;

    assign op       = mudi_op_e'(MDOp);
    assign is_mul   = (op == MUDI_MULT) || (op == MUDI_MULTU);
    assign is_div   = (op == MUDI_DIV)  || (op == MUDI_DIVU);
    assign div_zero = is_div && (B == 32'd0);
    assign accept   = MDStart && (is_mul || is_div) && !Busy && !req;

`ifdef MDU_DIVZERO_FAST_EN
    assign timer_load = accept && !div_zero;
`else
    assign timer_load = accept;
`endif
    assign timer_val = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    mudi_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .busy_o     (Busy),
        .done_o     (done)
    );

    // The result is computed at the accept edge and parked until the timer expires.
    assign res = is_div ? mudi_div(A, B, op == MUDI_DIV)
                        : mudi_mul(A, B, op == MUDI_MULT);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        ph_d = ph_q;
        pl_d = pl_q;
        pv_d = pv_q;
        if (accept) begin
            ph_d = res.hi;
            pl_d = res.lo;
            pv_d = !div_zero;
        end
        if (done && pv_q) begin
            hi_d = ph_q;
            lo_d = pl_q;
        end
        if (!req && !Busy) begin
            if (op == MUDI_MTHI) begin
                hi_d = A;
            end else if (op == MUDI_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
            ph_q <= '0;
            pl_q <= '0;
            pv_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            ph_q <= ph_d;
            pl_q <= pl_d;
            pv_q <= pv_d;
        end
    end

    // No bypass: a same-cycle mthi/mtlo becomes visible only after the edge.
    assign HLOut = (HLOp == HL_HI) ? hi_q : lo_q;

endmodule

// File: doc/mudi_unit.md
Name: mudi_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the decoder outputs MDOp, MDStart and HLOp with the forwarded rs/rt operands.
- Holds the architectural HI/LO registers and drives the mfhi/mflo read value.
- Exports Busy to the hazard unit, which stalls D-stage md-class instructions.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, Busy cycles for div/divu (≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous active-low reset
- MDOp  in  3  operation code (shared MUDI_* encoding)
- MDStart  in  1  start strobe for mult/multu/div/divu
- HLOp  in  1  read select: HL_HI→HI, HL_LO→LO
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- req  in  1  exception/interrupt flush from CP0; suppresses this cycle's E-stage effects
- Busy  out  1  registered; high while an operation is in flight
- HLOut  out  32  combinational HLOp ? HI : LO

Behaviour:
- Encodings: MUDI_OTH=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; HL_LO=0, HL_HI=1.
- Reset (reset==0 at edge): HI=0, LO=0, Busy=0, counter=0, pending results=0. Reset mid-operation abandons it; HI/LO stay 0.
- States: IDLE (Busy=0) and RUN (Busy=1).
- Accept condition: MDStart && !Busy && !req, in IDLE.
  - At the accept edge, compute the result into pending PH/PL, load counter = MULT_CYCLES or DIV_CYCLES, and enter RUN.
- mult: {PH,PL} = signed(A)*signed(B), 64-bit. multu: unsigned 64-bit product.
- div: PL = quotient truncated toward zero; PH = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives PL=0x80000000, PH=0.
- divu: unsigned quotient/remainder.
- Divide by B==0: no result. HI/LO are left unchanged at completion; the full DIV_CYCLES Busy still applies.
- RUN: counter decrements each cycle. On the edge where counter==1: HI←PH, LO←PL, Busy←0, return to IDLE.
  - Busy is therefore high for exactly N cycles after the accept edge.
  - HLOut shows the new value from the first cycle Busy is low.
- mthi/mtlo (MDOp=5/6) with !req && !Busy: HI←A or LO←A at the edge. Single-cycle; Busy is unaffected.
- MDStart, mthi or mtlo while Busy: ignored. The hazard unit guarantees this never occurs; the bench flags it as an error.
- req high: blocks a new start and MT writes that cycle. It does not abort an in-flight operation, which is already committed.
- MDOp=OTH, or MDOp in 1..4 without MDStart: no state change.
- HLOut is purely combinational from the HI/LO registers; no internal bypass of a same-cycle mthi/mtlo.

Optional Feature:
- Macro MDU_DIVZERO_FAST_EN.
- Defined: div/divu with B==0 is accepted but Busy stays 0 (no RUN state); HI/LO unchanged.
- Undefined: divide-by-zero takes the full DIV_CYCLES Busy, as above.

Decomposition:
- Shared package (head.v): MUDI_OTH..MUDI_MTLO, HL_HI/HL_LO, default cycle counts.
- One sub-module: mudi_timer, a loadable down-counter that generates Busy and the done pulse. The arithmetic stays in mudi_unit.

Test Plan:
- Reset then idle: HLOut=0 for both HLOp, Busy=0.
- mult A=0xFFFFFFFE(-2), B=3 with MDStart → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with same operands → HI=0x2, LO=0xFFFFFFFA.
- div A=-7 (0xFFFFFFF9), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. divu 7/0 → HI/LO unchanged, Busy 10 cycles, or 0 cycles with MDU_DIVZERO_FAST_EN.
- mthi A=0x12345678 → HLOut(HLOp=1)=0x12345678 the next cycle. Same op with req=1 → HI unchanged. MDStart with req=1 → Busy stays 0.
- Start mult, assert req in cycle 2 of RUN → operation still completes and HI/LO update. Second MDStart while Busy → ignored.
- reset=0 during cycle 3 of a div → next cycle Busy=0, HI=LO=0, and no late write.
